// File: rtl/vec_add_sequencer.sv
// Element-wise vector add/subtract that time-multiplexes one shared adder
// across all lanes, one lane per clock, with a per-lane signed-overflow mask.

module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic [WIDTH-1:0] out
);
  assign out = in1 + in2 + WIDTH'(cin);
endmodule

module vec_add_sequencer #(
  parameter int LANES = 4,
  parameter int WIDTH = 8,
  parameter int IDXW  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [LANES*WIDTH-1:0] vec_a,
  input  logic [LANES*WIDTH-1:0] vec_b,
  output logic                   busy,
  output logic                   done,
  output logic [LANES*WIDTH-1:0] vec_out,
  output logic [LANES-1:0]       ovf_mask
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                        state_q, state_d;
  logic [IDXW-1:0]               idx_q, idx_d;
  logic [LANES-1:0][WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic [LANES-1:0]              ovf_q, ovf_d;
  logic                          sub_q, sub_d;
  logic                          busy_q, busy_d, done_q, done_d;

  logic [WIDTH-1:0]              in1, in2, sum;

  // Subtract is A + ~B + 1, so the overflow rule below sees the inverted B.
  assign in1 = a_q[idx_q];
  assign in2 = sub_q ? ~b_q[idx_q] : b_q[idx_q];

  adder #(.WIDTH(WIDTH)) u_adder (
    .in1 (in1),
    .in2 (in2),
    .cin (sub_q),
    .out (sum)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: if (start) begin
        a_d     = vec_a;
        b_d     = vec_b;
        sub_d   = op_sub;
        res_d   = '0;
        ovf_d   = '0;
        idx_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        res_d[idx_q] = sum;
        ovf_d[idx_q] = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
        if (idx_q == IDXW'(LANES-1)) state_d = DONE;
        else                         idx_d   = idx_q + IDXW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status flags are registered off the next state so they line up with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      res_q   <= '0;
      ovf_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign vec_out  = res_q;
  assign ovf_mask = ovf_q;

endmodule

// File: tb/tb_vec_add_sequencer.sv
// Directed bench for vec_add_sequencer: hand-computed add/sub vectors, timing,
// start-while-busy, mid-op reset and operand stability.

module tb_vec_add_sequencer;
  localparam int LANES = 4;
  localparam int WIDTH = 8;

  logic                   clk = 1'b0;
  logic                   rst, start, op_sub;
  logic [LANES*WIDTH-1:0] vec_a, vec_b, vec_out;
  logic [LANES-1:0]       ovf_mask;
  logic                   busy, done;

  int tests = 0;
  int fails = 0;

  vec_add_sequencer #(.LANES(LANES), .WIDTH(WIDTH), .IDXW(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .op_sub   (op_sub),
    .vec_a    (vec_a),
    .vec_b    (vec_b),
    .busy     (busy),
    .done     (done),
    .vec_out  (vec_out),
    .ovf_mask (ovf_mask)
  );

  always #5 clk = ~clk;

  // Scenario vectors, lane 0 in the low byte.
  localparam logic [31:0] S1_A = 32'hE9D3610C, S1_B = 32'h87AF0FE8, S1_Y = 32'h708270F4;
  localparam logic [3:0]  S1_M = 4'b1000;
  localparam logic [31:0] S2_A = 32'h00D01752, S2_B = 32'h003DB238, S2_Y = 32'h000DC98A;
  localparam logic [3:0]  S2_M = 4'b0001;
  localparam logic [31:0] S3_A = 32'h0064D017, S3_B = 32'h80CE3DB2, S3_Y = 32'h80969365;
  localparam logic [3:0]  S3_M = 4'b1100;

  // Launches one op and watches ncyc cycles after the accepting edge.
  // inj_k: cycle at which a second start (with S3 operands) is pulsed; 0 = none.
  // scramble: randomise operand inputs every cycle after the start edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input int inj_k, input bit scramble, input int ncyc,
                       output int dcyc, output int ndone, output int busy_bad);
    dcyc = 0; ndone = 0; busy_bad = 0;
    @(negedge clk);
    vec_a = a; vec_b = b; op_sub = sub; start = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin ndone++; dcyc = k; end
      if (busy !== (k <= LANES + 1)) busy_bad++;
      start = (k == inj_k);
      if (k == inj_k) begin vec_a = S3_A; vec_b = S3_B; op_sub = 1'b1; end
      if (scramble) begin vec_a = $urandom; vec_b = $urandom; op_sub = $urandom_range(0, 1) != 0; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op_sub = 1'b0; vec_a = '0; vec_b = '0;
    repeat (3) @(negedge clk);
    tests++; if (busy !== 1'b0)      begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0)      begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (vec_out !== 32'h0)  begin fails++; $display("FAIL reset_vec_out got %h want 0", vec_out); end
    tests++; if (ovf_mask !== 4'h0)  begin fails++; $display("FAIL reset_ovf got %b want 0", ovf_mask); end
    rst = 1'b0;
  endtask

  task automatic test_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] y, input logic [3:0] m,
                         input int inj_k, input bit scramble);
    int dc, nd, bb;
    do_op(a, b, sub, inj_k, scramble, LANES + 4, dc, nd, bb);
    tests++; if (vec_out !== y)  begin fails++; $display("FAIL %s_vec_out got %h want %h", name, vec_out, y); end
    tests++; if (ovf_mask !== m) begin fails++; $display("FAIL %s_ovf got %b want %b", name, ovf_mask, m); end
    tests++; if (nd !== 1)       begin fails++; $display("FAIL %s_done_count got %0d want 1", name, nd); end
    tests++; if (dc !== LANES+1) begin fails++; $display("FAIL %s_done_cycle got %0d want %0d", name, dc, LANES+1); end
    tests++; if (bb !== 0)       begin fails++; $display("FAIL %s_busy got %0d bad cycles want 0", name, bb); end
  endtask

  task automatic test_back_to_back;
    int dc, nd, bb;
    do_op(S1_A, S1_B, 1'b0, 0, 1'b0, LANES + 1, dc, nd, bb);
    tests++; if (vec_out !== S1_Y) begin fails++; $display("FAIL b2b_first got %h want %h", vec_out, S1_Y); end
    do_op(S3_A, S3_B, 1'b1, 0, 1'b0, LANES + 4, dc, nd, bb);
    tests++; if (vec_out !== S3_Y)  begin fails++; $display("FAIL b2b_vec_out got %h want %h", vec_out, S3_Y); end
    tests++; if (ovf_mask !== S3_M) begin fails++; $display("FAIL b2b_ovf got %b want %b", ovf_mask, S3_M); end
    tests++; if (dc !== LANES+1 || nd !== 1) begin fails++; $display("FAIL b2b_done got cycle %0d count %0d want %0d/1", dc, nd, LANES+1); end
  endtask

  task automatic test_reset_mid;
    int nd = 0;
    @(negedge clk);
    vec_a = S1_A; vec_b = S1_B; op_sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;   // cycle 1, index 0
    @(negedge clk);                 // cycle 2, index 1
    @(negedge clk); rst = 1'b1;     // cycle 3, index 2
    @(negedge clk); rst = 1'b0;
    tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL midrst_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0)     begin fails++; $display("FAIL midrst_done got %b want 0", done); end
    tests++; if (vec_out !== 32'h0) begin fails++; $display("FAIL midrst_vec_out got %h want 0", vec_out); end
    tests++; if (ovf_mask !== 4'h0) begin fails++; $display("FAIL midrst_ovf got %b want 0", ovf_mask); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    tests++; if (nd !== 0) begin fails++; $display("FAIL midrst_late_done got %0d pulses want 0", nd); end
    test_op("after_rst", S2_A, S2_B, 1'b0, S2_Y, S2_M, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_op("add", S1_A, S1_B, 1'b0, S1_Y, S1_M, 0, 1'b0);
    test_op("add_ovf", S2_A, S2_B, 1'b0, S2_Y, S2_M, 0, 1'b0);
    test_op("sub", S3_A, S3_B, 1'b1, S3_Y, S3_M, 0, 1'b0);
    test_op("busy_start", S1_A, S1_B, 1'b0, S1_Y, S1_M, 2, 1'b0);
    test_back_to_back();
    test_reset_mid();
    test_op("stability", S2_A, S2_B, 1'b0, S2_Y, S2_M, 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
